// File: rtl/quad_pkg.sv
// quad_pkg: shared state, phase and direction definitions for the quadrature emitter.
package quad_pkg;
  typedef enum logic [2:0] {Q_IDLE, Q_P1, Q_P2, Q_P3, Q_P4} q_state_t;
  localparam logic [1:0] QAB_IDLE = 2'b00;
  localparam logic [1:4][1:0] QAB_UP = {2'b10, 2'b11, 2'b01, 2'b00};
  localparam logic [1:4][1:0] QAB_DOWN = {2'b01, 2'b11, 2'b10, 2'b00};
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  function automatic logic [1:0] phase_ab(input q_state_t s, input logic dir);
    return (s == Q_IDLE) ? QAB_IDLE : (dir == DIR_DOWN) ? QAB_DOWN[s] : QAB_UP[s];
  endfunction
endpackage

// File: rtl/quadrature_emitter_if.sv
// quadrature_emitter_if: request inputs and A/B/switch/status outputs of the emitter.
// master drives step_up/step_down/press; slave drives out_a/out_b/out_switch/busy/overflow.
interface quadrature_emitter_if;
  logic step_up, step_down, press;
  logic out_a, out_b, out_switch, busy, overflow;
  modport master (output step_up, step_down, press, input out_a, out_b, out_switch, busy, overflow);
  modport slave (input step_up, step_down, press, output out_a, out_b, out_switch, busy, overflow);
endinterface

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns a one-cycle trig into a registered level held LEN cycles, retriggerable.
// Ports: clk, rst (sync, active-high), trig in, level out.
module pulse_stretcher #(
  parameter int LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic level
);
  localparam int CW = $clog2(LEN + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  always_comb begin
    cnt_d = trig ? CW'(LEN) : (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    level_d = cnt_d != '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      level_q <= level_d;
    end
  end
  assign level = level_q;
endmodule

// File: rtl/quadrature_emitter.sv
// quadrature_emitter: plays queued up/down detents as Gray-coded A/B phases plus a stretched switch level.
// Ports: clk, rst (sync, active-high), bus (slave): step_up/step_down/press in; out_a/out_b/out_switch/busy/overflow out.
module quadrature_emitter
  import quad_pkg::*;
#(
  parameter int PHASE_CYCLES = 4,
  parameter int MAX_PENDING = 7,
  parameter int BUTTON_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  quadrature_emitter_if.slave bus
);
  localparam int PW = $clog2(MAX_PENDING) + 2;
  localparam int CW = $clog2(PHASE_CYCLES + 1);
  localparam logic signed [PW-1:0] PMAX = PW'(MAX_PENDING);
  q_state_t state_q, state_d;
  logic dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [PW-1:0] pending_q, pending_d, net, sum, cons;
  logic [1:0] ab_q, ab_d;
  logic busy_q, busy_d, ovf_q, ovf_d;
  logic phase_done, start, sat;
  always_comb begin
    net = (bus.step_up & ~bus.step_down) ? PW'(1) : (bus.step_down & ~bus.step_up) ? '1 : '0;
    sum = pending_q + net;
    sat = (sum > PMAX) || (sum < -PMAX);
    phase_done = cnt_q == CW'(PHASE_CYCLES);
    // A new detent starts from idle or straight out of a finished P4.
    start = (pending_q != '0) && ((state_q == Q_IDLE) || (state_q == Q_P4 && phase_done));
    cons = !start ? '0 : (pending_q < 0) ? '1 : PW'(1);
    pending_d = (sat ? pending_q : sum) - cons;
    state_d = start ? Q_P1 : (state_q == Q_IDLE || !phase_done) ? state_q :
              (state_q == Q_P4) ? Q_IDLE : q_state_t'(state_q + 3'd1);
    dir_d = start ? ((pending_q < 0) ? DIR_DOWN : DIR_UP) : dir_q;
    cnt_d = (state_d == Q_IDLE) ? '0 : (start || phase_done) ? CW'(1) : cnt_q + CW'(1);
    ab_d = phase_ab(state_d, dir_d);
    busy_d = (state_d != Q_IDLE) || (pending_d != '0);
    ovf_d = sat;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= Q_IDLE;
      dir_q <= DIR_UP;
      cnt_q <= '0;
      pending_q <= '0;
      ab_q <= QAB_IDLE;
      busy_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      pending_q <= pending_d;
      ab_q <= ab_d;
      busy_q <= busy_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.out_a = ab_q[1];
  assign bus.out_b = ab_q[0];
  assign bus.busy = busy_q;
  assign bus.overflow = ovf_q;
  pulse_stretcher #(.LEN(BUTTON_CYCLES)) u_switch (
    .clk(clk),
    .rst(rst),
    .trig(bus.press),
    .level(bus.out_switch)
  );
endmodule
